// File: rtl/gpio_slave.sv
// GPIO bus slave: synchronised inputs, byte-writable output register, gnt/rvalid handshake.
// Optional input rising-edge interrupt enabled by defining GPIO_IRQ_EN.
module gpio_slave #(
    parameter logic [31:0] GPIN_ADDR   = 32'h2000_1000,
    parameter logic [31:0] GPOUT_ADDR  = 32'h2000_2000,
    parameter int unsigned WIDTH       = 32,
    parameter logic [31:0] GPOUT_RESET = 32'h0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             gpio_sel,
    input  logic             gpio_write,
    input  logic [31:0]      data_addr,
    input  logic [3:0]       data_be,
    input  logic [31:0]      data_wdata,
    output logic             gpio_gnt,
    output logic             gpio_rvalid,
    output logic [31:0]      gpio_rdata,
    input  logic [WIDTH-1:0] gpin,
    output logic [WIDTH-1:0] gpout
`ifdef GPIO_IRQ_EN
    ,
    output logic             gpio_irq
`endif
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_gpout;
    logic             r_rvalid;
    logic [31:0]      r_rdata;

    logic [WIDTH-1:0] w_sync_in;
    logic             w_hit_gpin;
    logic             w_hit_gpout;
    logic             w_rd_gpin;
    logic             w_wr_gpout;
    logic [31:0]      w_gpout_ext;
    logic [31:0]      w_gpout_wr;
    logic [31:0]      w_rdata_next;

    assign w_sync_in   = r_sync[SYNC_STAGES-1];
    assign w_hit_gpin  = (data_addr == GPIN_ADDR);
    assign w_hit_gpout = (data_addr == GPOUT_ADDR);
    assign w_rd_gpin   = gpio_sel & ~gpio_write & w_hit_gpin;
    assign w_wr_gpout  = gpio_sel & gpio_write & w_hit_gpout;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= gpin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Byte-lane merge done on a 32-bit view so lanes above WIDTH simply fall off.
    always_comb begin
        w_gpout_ext = '0;
        w_gpout_ext[WIDTH-1:0] = r_gpout;
        w_gpout_wr = w_gpout_ext;
        for (int i = 0; i < 4; i++) begin
            if (data_be[i]) begin
                w_gpout_wr[8*i +: 8] = data_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_rdata_next = '0;
        if (!gpio_write) begin
            if (w_hit_gpin) begin
                w_rdata_next[WIDTH-1:0] = w_sync_in;
            end else if (w_hit_gpout) begin
                w_rdata_next[WIDTH-1:0] = r_gpout;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_gpout  <= GPOUT_RESET[WIDTH-1:0];
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= gpio_sel;
            if (gpio_sel) begin
                r_rdata <= w_rdata_next;
            end
            if (w_wr_gpout) begin
                r_gpout <= w_gpout_wr[WIDTH-1:0];
            end
        end
    end

    assign gpio_gnt    = gpio_sel;
    assign gpio_rvalid = r_rvalid;
    assign gpio_rdata  = r_rdata;
    assign gpout       = r_gpout;

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] r_sync_prev;
    logic [WIDTH-1:0] r_edge;
    logic             r_irq;
    logic [WIDTH-1:0] w_rise;

    assign w_rise = w_sync_in & ~r_sync_prev;

    // A rise coinciding with the read-clear survives the clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sync_prev <= '0;
            r_edge      <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_sync_prev <= w_sync_in;
            r_edge      <= (w_rd_gpin ? '0 : r_edge) | w_rise;
            r_irq       <= |r_edge;
        end
    end

    assign gpio_irq = r_irq;
`endif

endmodule

// File: tb/tb_gpio_slave.sv
// Scoreboard bench for gpio_slave: random bus traffic checked against a behavioural register model.
// Interrupt checks compiled in only when GPIO_IRQ_EN is defined.
module tb_gpio_slave;

    localparam logic [31:0] GPIN_ADDR   = 32'h2000_1000;
    localparam logic [31:0] GPOUT_ADDR  = 32'h2000_2000;
    localparam int unsigned WIDTH       = 32;
    localparam logic [31:0] GPOUT_RESET = 32'h0;
    localparam int unsigned SYNC_STAGES = 2;

    logic             HCLK;
    logic             HRESETn;
    logic             gpio_sel;
    logic             gpio_write;
    logic [31:0]      data_addr;
    logic [3:0]       data_be;
    logic [31:0]      data_wdata;
    logic             gpio_gnt;
    logic             gpio_rvalid;
    logic [31:0]      gpio_rdata;
    logic [WIDTH-1:0] gpin;
    logic [WIDTH-1:0] gpout;
`ifdef GPIO_IRQ_EN
    logic             gpio_irq;
`endif

    gpio_slave #(
        .GPIN_ADDR   (GPIN_ADDR),
        .GPOUT_ADDR  (GPOUT_ADDR),
        .WIDTH       (WIDTH),
        .GPOUT_RESET (GPOUT_RESET),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .gpio_sel    (gpio_sel),
        .gpio_write  (gpio_write),
        .data_addr   (data_addr),
        .data_be     (data_be),
        .data_wdata  (data_wdata),
        .gpio_gnt    (gpio_gnt),
        .gpio_rvalid (gpio_rvalid),
        .gpio_rdata  (gpio_rdata),
        .gpin        (gpin),
        .gpout       (gpout)
`ifdef GPIO_IRQ_EN
        ,
        .gpio_irq    (gpio_irq)
`endif
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] model_gpin;
    logic [31:0] model_gpout;
    logic [31:0] mask;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Response is due exactly one cycle after the accept edge.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            check("gnt", {31'd0, gpio_gnt}, {31'd0, gpio_sel});
            if (q.size() != 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                check("rvalid", {31'd0, gpio_rvalid}, 32'd1);
                if (gpio_rvalid) check("rdata", gpio_rdata, e.data);
            end else begin
                check("rvalid_idle", {31'd0, gpio_rvalid}, 32'd0);
            end
        end
    end

    // Model applies each access in issue order; the bus sees them in the same order.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
        exp_t e;
        e.due  = cyc + 1;
        e.data = 32'd0;
        if (!wr) begin
            if (addr == GPIN_ADDR) e.data = model_gpin & mask;
            else if (addr == GPOUT_ADDR) e.data = model_gpout;
        end else if (addr == GPOUT_ADDR) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model_gpout[8*i +: 8] = wd[8*i +: 8];
            end
            model_gpout &= mask;
        end
        q.push_back(e);
        gpio_sel   = 1'b1;
        gpio_write = wr;
        data_addr  = addr;
        data_be    = be;
        data_wdata = wd;
        @(posedge HCLK);
        #1;
        gpio_sel   = 1'b0;
        gpio_write = 1'b0;
    endtask

    task automatic idle(input int n);
        gpio_sel = 1'b0;
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic set_gpin(input logic [31:0] v);
        gpin = v[WIDTH-1:0];
        idle(SYNC_STAGES + 1);
        model_gpin = v & mask;
    endtask

    initial begin
        logic [63:0] m64;
        m64  = (64'd1 << WIDTH) - 64'd1;
        mask = m64[31:0];
        model_gpin  = 32'd0;
        model_gpout = GPOUT_RESET & mask;
        HRESETn    = 1'b0;
        gpio_sel   = 1'b0;
        gpio_write = 1'b0;
        data_addr  = 32'd0;
        data_be    = 4'd0;
        data_wdata = 32'd0;
        gpin       = '0;

        repeat (2) @(posedge HCLK);
        #1;
        check("reset_rvalid", {31'd0, gpio_rvalid}, 32'd0);
        check("reset_rdata", gpio_rdata, 32'd0);
        check("reset_gpout", {{(32-WIDTH){1'b0}}, gpout}, GPOUT_RESET & mask);
        HRESETn = 1'b1;
        idle(2);
        check("idle_gpout", {{(32-WIDTH){1'b0}}, gpout}, 32'd0);

        // Input read after settling
        set_gpin(32'hA5A5_0F0F);
        issue(1'b0, GPIN_ADDR, 4'h0, 32'd0);
        idle(2);

        // Byte-lane writes then back-to-back read
        issue(1'b1, GPOUT_ADDR, 4'b1111, 32'h1234_5678);
        issue(1'b1, GPOUT_ADDR, 4'b0100, 32'hFFFF_FFFF);
        issue(1'b0, GPOUT_ADDR, 4'h0, 32'd0);
        idle(2);
        check("gpout_lanes", {{(32-WIDTH){1'b0}}, gpout}, 32'h12FF_5678 & mask);

        // Three-deep pipeline
        issue(1'b0, GPIN_ADDR, 4'h0, 32'd0);
        issue(1'b1, GPOUT_ADDR, 4'b1111, 32'h0000_00AA);
        issue(1'b0, GPOUT_ADDR, 4'h0, 32'd0);
        idle(2);

        // Write to the read-only input word
        issue(1'b1, GPIN_ADDR, 4'b1111, 32'hDEAD_BEEF);
        issue(1'b0, GPIN_ADDR, 4'h0, 32'd0);
        issue(1'b0, GPOUT_ADDR, 4'h0, 32'd0);
        idle(2);
        check("gpout_after_gpin_wr", {{(32-WIDTH){1'b0}}, gpout}, model_gpout);

        // Decoder-fault address
        issue(1'b1, 32'h2000_3000, 4'b1111, 32'h5555_5555);
        issue(1'b0, 32'h2000_3000, 4'h0, 32'd0);
        idle(2);

        // Reset the cycle after a write accept: its response must never appear
        issue(1'b1, GPOUT_ADDR, 4'b1111, 32'hCAFE_F00D);
        HRESETn = 1'b0;
        q.delete();
        model_gpout = GPOUT_RESET & mask;
        #1;
        check("midreset_rvalid", {31'd0, gpio_rvalid}, 32'd0);
        check("midreset_gpout", {{(32-WIDTH){1'b0}}, gpout}, GPOUT_RESET & mask);
        @(negedge HCLK);
        check("midreset_rvalid2", {31'd0, gpio_rvalid}, 32'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        idle(SYNC_STAGES + 1);
        issue(1'b0, GPOUT_ADDR, 4'h0, 32'd0);
        issue(1'b0, GPIN_ADDR, 4'h0, 32'd0);
        idle(2);

`ifdef GPIO_IRQ_EN
        begin
            bit seen;
            set_gpin(32'd0);
            issue(1'b0, GPIN_ADDR, 4'h0, 32'd0);
            idle(2);
            check("irq_quiet", {31'd0, gpio_irq}, 32'd0);
            gpin[3] = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < SYNC_STAGES + 2; i++) begin
                @(posedge HCLK);
                #1;
                if (gpio_irq) seen = 1'b1;
            end
            check("irq_rise", {31'd0, seen}, 32'd1);
            model_gpin = 32'h8 & mask;
            issue(1'b0, GPIN_ADDR, 4'h0, 32'd0);
            idle(1);
            check("irq_cleared", {31'd0, gpio_irq}, 32'd0);
            idle(1);
            seen = 1'b0;
            for (int i = 0; i < SYNC_STAGES + 2; i++) begin
                @(posedge HCLK);
                #1;
                if (gpio_irq) seen = 1'b1;
            end
            check("irq_no_new_edge", {31'd0, seen}, 32'd0);
            // Bit 5 reaches sync_in so its rise lands on the clearing accept edge.
            gpin[5] = 1'b1;
            model_gpin = 32'h28 & mask;
            idle(SYNC_STAGES);
            issue(1'b0, GPIN_ADDR, 4'h0, 32'd0);
            idle(1);
            check("irq_coincident", {31'd0, gpio_irq}, 32'd1);
            idle(1);
            check("irq_coincident_hold", {31'd0, gpio_irq}, 32'd1);
        end
`endif

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            int unsigned sel;
            logic [31:0] addr;
            sel = $urandom_range(0, 9);
            if (sel < 4) addr = GPIN_ADDR;
            else if (sel < 9) addr = GPOUT_ADDR;
            else addr = $urandom;
            if ($urandom_range(0, 15) == 0) set_gpin($urandom);
            issue(1'($urandom_range(0, 1)), addr, 4'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        check("gpout_final", {{(32-WIDTH){1'b0}}, gpout}, model_gpout);
        check("drain", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
